maple_tx: RTL and testbench



---
 rtl/maple_tx_pkg.sv | 36 +++
 rtl/maple_tx_if.sv | 17 +
 rtl/maple_bit_phaser.sv | 43 ++++
 rtl/maple_tx.sv | 172 +++++++++++++++++
 tb/tb_maple_tx.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/maple_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : maple_tx_pkg
// Description : Shared Maple bus definitions: FSM state encodings, pattern
//               step counts and step indices used by the transmitter (and by
//               the future receiver, so both agree on the line protocol).
// Revision    : 1.0 - initial release
// ============================================================================
package maple_tx_pkg;

    // Transmitter frame states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_CRC   = 3'd4,
        ST_END   = 3'd5
    } state_t;

    // Pattern lengths in ticks
    localparam int unsigned c_start_steps = 10;
    localparam int unsigned c_end_steps   = 5;
    localparam int unsigned c_bit_steps   = 3;

    // Step indices inside each pattern
    localparam logic [3:0] c_start_first = 4'd0;
    localparam logic [3:0] c_start_last  = 4'(c_start_steps - 1);
    localparam logic [3:0] c_end_last    = 4'(c_end_steps - 1);
    localparam logic [1:0] c_bit_last    = 2'(c_bit_steps - 1);

    // First bit sent in each byte (MSB first)
    localparam logic [2:0] c_msb_index   = 3'd7;

endpackage : maple_tx_pkg
`default_nettype wire

// File: rtl/maple_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : maple_tx_if
// Description : Byte-stream handshake between the TX buffer and the Maple
//               frame transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface maple_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
    modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface : maple_tx_if
`default_nettype wire

// File: rtl/maple_bit_phaser.sv
`default_nettype none
// ============================================================================
// Module      : maple_bit_phaser
// Description : Next-level generator for one Maple data bit. Odd bit indices
//               use phase A (data on pin5, strobe on pin1), even indices use
//               phase B (data on pin1, strobe on pin5).
// Revision    : 1.0 - initial release
// ============================================================================
module maple_bit_phaser
    import maple_tx_pkg::*;
(
    input  wire logic       i_bit_val,
    input  wire logic       i_phase_a,
    input  wire logic [1:0] i_step,
    input  wire logic       i_cur_p1,
    input  wire logic       i_cur_p5,
    output logic            o_next_p1,
    output logic            o_next_p5,
    output logic            o_bit_done
);

    // Each step changes exactly one line; the other holds its level
    always_comb begin
        o_next_p1  = i_cur_p1;
        o_next_p5  = i_cur_p5;
        o_bit_done = (i_step == c_bit_last);
        if (i_phase_a) begin
            case (i_step)
                2'd0:    o_next_p5 = i_bit_val;
                2'd1:    o_next_p1 = 1'b0;
                default: o_next_p5 = 1'b1;
            endcase
        end else begin
            case (i_step)
                2'd0:    o_next_p1 = i_bit_val;
                2'd1:    o_next_p5 = 1'b0;
                default: o_next_p1 = 1'b1;
            endcase
        end
    end

endmodule : maple_bit_phaser
`default_nettype wire

// File: rtl/maple_tx.sv
`default_nettype none
// ============================================================================
// Module      : maple_tx
// Description : Maple bus frame transmitter. Emits lead, start pattern,
//               two-phase data bytes, optional XOR checksum byte and end
//               pattern, one line step per divider tick.
// Revision    : 1.0 - initial release
// ============================================================================
module maple_tx
    import maple_tx_pkg::*;
#(
    parameter bit APPEND_CRC = 1'b1
) (
    input  wire logic   clk,
    input  wire logic   rst,
    input  wire logic   tick,
    maple_tx_if.slave   tx,
    output logic        out_p1,
    output logic        out_p5,
    output logic        oe,
    output logic        busy,
    output logic        underrun
);

    state_t     r_state;
    logic [3:0] r_step;
    logic [2:0] r_bit;
    logic [7:0] r_sh;
    logic [7:0] r_crc;
    logic       r_last;
    logic       r_p1;
    logic       r_p5;
    logic       r_oe;
    logic       r_underrun;

    logic       w_next_p1;
    logic       w_next_p5;
    logic       w_bit_done;
    logic       w_byte_end;
    logic       w_ready;

    maple_bit_phaser u_phaser (
        .i_bit_val  (r_sh[r_bit]),
        .i_phase_a  (r_bit[0]),
        .i_step     (r_step[1:0]),
        .i_cur_p1   (r_p1),
        .i_cur_p5   (r_p5),
        .o_next_p1  (w_next_p1),
        .o_next_p5  (w_next_p5),
        .o_bit_done (w_bit_done)
    );

    // Byte boundary: the tick that applies the final step of bit 0.
    // Ready is open in IDLE and at a boundary that expects another byte.
    always_comb begin
        w_byte_end = tick && w_bit_done && (r_bit == 3'd0);
        w_ready    = !rst && ((r_state == ST_IDLE) ||
                              ((r_state == ST_DATA) && w_byte_end && !r_last));
    end

    assign tx.tx_ready = w_ready;
    assign out_p1      = r_p1;
    assign out_p5      = r_p5;
    assign oe          = r_oe;
    assign busy        = (r_state != ST_IDLE);
    assign underrun    = r_underrun;

    // Frame FSM, shift register, checksum and registered line levels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_step     <= 4'd0;
            r_bit      <= c_msb_index;
            r_sh       <= 8'd0;
            r_crc      <= 8'd0;
            r_last     <= 1'b0;
            r_p1       <= 1'b1;
            r_p5       <= 1'b1;
            r_oe       <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Acceptance wins over a coincident tick
                    if (tx.tx_valid) begin
                        r_sh       <= tx.tx_data;
                        r_crc      <= tx.tx_data;
                        r_last     <= tx.tx_last;
                        r_underrun <= 1'b0;
                        r_state    <= ST_LEAD;
                    end
                end
                ST_LEAD: begin
                    if (tick) begin
                        r_oe    <= 1'b1;
                        r_p1    <= 1'b1;
                        r_p5    <= 1'b1;
                        r_step  <= c_start_first;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (r_step == c_start_first) begin
                            r_p1   <= 1'b0;
                            r_step <= r_step + 4'd1;
                        end else if (r_step == c_start_last) begin
                            r_p1    <= 1'b1;
                            r_step  <= 4'd0;
                            r_bit   <= c_msb_index;
                            r_state <= ST_DATA;
                        end else begin
                            // Four pin5 pulses: low on odd steps, high on even
                            r_p5   <= ~r_step[0];
                            r_step <= r_step + 4'd1;
                        end
                    end
                end
                ST_DATA, ST_CRC: begin
                    if (tick) begin
                        r_p1 <= w_next_p1;
                        r_p5 <= w_next_p5;
                        if (!w_bit_done) begin
                            r_step <= r_step + 4'd1;
                        end else begin
                            r_step <= 4'd0;
                            if (r_bit != 3'd0) begin
                                r_bit <= r_bit - 3'd1;
                            end else begin
                                r_bit <= c_msb_index;
                                if (r_state == ST_CRC) begin
                                    r_state <= ST_END;
                                end else if (!r_last) begin
                                    if (tx.tx_valid) begin
                                        r_sh   <= tx.tx_data;
                                        r_crc  <= r_crc ^ tx.tx_data;
                                        r_last <= tx.tx_last;
                                    end else begin
                                        r_underrun <= 1'b1;
                                        r_state    <= ST_END;
                                    end
                                end else if (APPEND_CRC) begin
                                    r_sh    <= r_crc;
                                    r_state <= ST_CRC;
                                end else begin
                                    r_state <= ST_END;
                                end
                            end
                        end
                    end
                end
                ST_END: begin
                    if (tick) begin
                        if (r_step == c_end_last) begin
                            r_p5    <= 1'b1;
                            r_oe    <= 1'b0;
                            r_step  <= 4'd0;
                            r_state <= ST_IDLE;
                        end else begin
                            // Two pin1 pulses while pin5 stays low
                            r_p1   <= r_step[0];
                            r_step <= r_step + 4'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule : maple_tx
`default_nettype wire

// File: tb/tb_maple_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_maple_tx
// Description : Scoreboard bench for maple_tx. Instance 0 appends the
//               checksum, instance 1 does not. A per-tick line decoder
//               rebuilds bytes and frame shape and checks them against
//               expectations queued by the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maple_tx;
    import maple_tx_pkg::*;

    typedef struct {
        int len;
        int rdy;
        bit ur;
    } frame_t;

    logic clk;
    logic rst;
    logic tick;
    logic p1_0, p5_0, oe_0, busy_0, ur_0;
    logic p1_1, p5_1, oe_1, busy_1, ur_1;

    maple_tx_if if0 ();
    maple_tx_if if1 ();

    maple_tx #(.APPEND_CRC(1'b1)) dut_crc (
        .clk(clk), .rst(rst), .tick(tick), .tx(if0),
        .out_p1(p1_0), .out_p5(p5_0), .oe(oe_0), .busy(busy_0), .underrun(ur_0)
    );

    maple_tx #(.APPEND_CRC(1'b0)) dut_nocrc (
        .clk(clk), .rst(rst), .tick(tick), .tx(if1),
        .out_p1(p1_1), .out_p5(p5_1), .oe(oe_1), .busy(busy_1), .underrun(ur_1)
    );

    int vectors = 0;
    int miscompares = 0;

    // Scoreboard queues per instance
    logic [7:0] eb0[$];
    logic [7:0] eb1[$];
    frame_t     ef0[$];
    frame_t     ef1[$];

    // Decoder state per instance
    int         steps[2];
    bit         in_fr[2];
    logic [7:0] cur[2];
    int         pat_err[2];
    int         rdy_cnt[2];
    int         sig[2];
    int         last_sig[2];
    logic [1:0] hist[2][5];
    logic [2:0] prev_l[2];
    int         stab_viol = 0;
    logic       tick_q = 1'b0;
    int         tick_mode = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Tick generator: fixed 6-clk period or random 1..20 clk gaps
    initial begin
        int cnt;
        cnt = 0;
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (cnt == 0) begin
                tick = 1'b1;
                cnt = (tick_mode == 0) ? 5 : int'($urandom_range(1, 20)) - 1;
            end else begin
                tick = 1'b0;
                cnt--;
            end
        end
    end

    task automatic byte_done(input int i, input logic [7:0] b);
        logic [7:0] e;
        if (i == 0) begin
            if (eb0.size() == 0) begin chk("unexpected_byte_crc", int'(b), -1); return; end
            e = eb0.pop_front();
            chk("byte_crc_inst", int'(b), int'(e));
        end else begin
            if (eb1.size() == 0) begin chk("unexpected_byte_nocrc", int'(b), -1); return; end
            e = eb1.pop_front();
            chk("byte_nocrc_inst", int'(b), int'(e));
        end
    endtask

    task automatic frame_end(input int i, input logic busy, input logic ur);
        frame_t f;
        if (i == 0) begin
            if (ef0.size() == 0) begin chk("unexpected_frame_crc", steps[i], -1); return; end
            f = ef0.pop_front();
        end else begin
            if (ef1.size() == 0) begin chk("unexpected_frame_nocrc", steps[i], -1); return; end
            f = ef1.pop_front();
        end
        chk("frame_tick_count", steps[i], f.len);
        chk("end_pattern", int'({hist[i][0], hist[i][1], hist[i][2], hist[i][3], hist[i][4]}),
            int'(10'b00_10_00_10_11));
        chk("pattern_errors", pat_err[i], 0);
        chk("busy_falls_with_oe", int'(busy), 0);
        chk("underrun_flag", int'(ur), int'(f.ur));
        chk("ready_pulses", rdy_cnt[i], f.rdy);
        last_sig[i] = sig[i];
    endtask

    // Per-tick line decoder for one instance
    task automatic mon(input int i, input bit st, input logic p1, input logic p5,
                       input logic oe, input logic busy, input logic rdy, input logic ur);
        int k, o, b, s;
        logic v;
        if (!rst && !st && ({p1, p5, oe} != prev_l[i])) stab_viol++;
        prev_l[i] = {p1, p5, oe};
        if (rst) begin
            in_fr[i] = 1'b0;
            return;
        end
        if (busy && rdy && in_fr[i]) begin
            rdy_cnt[i]++;
            if (!tick || ((steps[i] - 11) % 24 != 23)) pat_err[i]++;
        end
        if (!st) return;
        if (!in_fr[i]) begin
            if (oe) begin
                in_fr[i]   = 1'b1;
                steps[i]   = 1;
                pat_err[i] = (p1 && p5 && busy) ? 0 : 1;
                rdy_cnt[i] = 0;
                sig[i]     = int'({p1, p5, oe});
            end
            return;
        end
        steps[i]++;
        k = steps[i];
        sig[i] = sig[i] * 33 + int'({p1, p5, oe});
        for (int j = 0; j < 4; j++) hist[i][j] = hist[i][j + 1];
        hist[i][4] = {p1, p5};
        if (!oe) begin
            in_fr[i] = 1'b0;
            frame_end(i, busy, ur);
            return;
        end
        if (!busy) pat_err[i]++;
        if (k <= 11) begin
            s = k - 2;
            if (p1 != (s == 9)) pat_err[i]++;
            if (p5 != ((s == 0 || s == 9) ? 1'b1 : (s % 2 == 0))) pat_err[i]++;
        end else begin
            o = k - 12;
            if (o % 3 == 0) begin
                b = 7 - ((o / 3) % 8);
                v = (b % 2 == 1) ? p5 : p1;
                cur[i] = {cur[i][6:0], v};
                if (b == 0) byte_done(i, cur[i]);
            end
            if ((o % 24 == 23) && !(p1 && !p5)) pat_err[i]++;
        end
    endtask

    // Monitor: sample away from the active edge
    always @(negedge clk) begin
        bit st;
        st = tick_q;
        mon(0, st, p1_0, p5_0, oe_0, busy_0, if0.tx_ready, ur_0);
        mon(1, st, p1_1, p5_1, oe_1, busy_1, if1.tx_ready, ur_1);
        tick_q = tick;
    end

    // Called at posedge+#1; returns at posedge+#1 after the accepting edge
    task automatic send_byte(input int i, input logic [7:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        if (i == 0) begin if0.tx_valid = 1'b1; if0.tx_data = d; if0.tx_last = l; end
        else        begin if1.tx_valid = 1'b1; if1.tx_data = d; if1.tx_last = l; end
        for (int n = 0; n < 5000; n++) begin
            @(negedge clk);
            if ((i == 0) ? if0.tx_ready : if1.tx_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk);
        #1;
        if0.tx_valid = 1'b0;
        if1.tx_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_done(input int i);
        int n;
        n = 0;
        while (((i == 0) ? ef0.size() : ef1.size()) != 0) begin
            @(negedge clk);
            n++;
            if (n > 6000) begin chk("frame_timeout", 0, 1); break; end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int i, input int len, input int rdy, input bit ur);
        frame_t f;
        f.len = len; f.rdy = rdy; f.ur = ur;
        if (i == 0) ef0.push_back(f); else ef1.push_back(f);
    endtask

    initial begin
        int sig_reg, n, viol;
        bit seen;
        rst = 1'b1;
        if0.tx_valid = 1'b0; if0.tx_data = 8'h00; if0.tx_last = 1'b0;
        if1.tx_valid = 1'b0; if1.tx_data = 8'h00; if1.tx_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_oe", int'(oe_0), 0);
        chk("reset_lines", int'({p1_0, p5_0}), 3);
        chk("reset_busy", int'(busy_0), 0);
        chk("reset_underrun", int'(ur_0), 0);
        chk("reset_ready", int'(if0.tx_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", int'(if0.tx_ready), 1);
        @(posedge clk); #1;

        // Single byte, no checksum, regular ticks
        tick_mode = 0;
        eb1.push_back(8'hA5);
        push_frame(1, 40, 0, 1'b0);
        send_byte(1, 8'hA5, 1'b1);
        wait_done(1);
        sig_reg = last_sig[1];

        // Same frame with irregular tick gaps
        tick_mode = 1;
        eb1.push_back(8'hA5);
        push_frame(1, 40, 0, 1'b0);
        send_byte(1, 8'hA5, 1'b1);
        wait_done(1);
        chk("irregular_tick_waveform", last_sig[1], sig_reg);
        tick_mode = 0;

        // Three bytes plus checksum 12^34^56 = 70
        eb0.push_back(8'h12); eb0.push_back(8'h34);
        eb0.push_back(8'h56); eb0.push_back(8'h70);
        push_frame(0, 112, 2, 1'b0);
        send_byte(0, 8'h12, 1'b0);
        send_byte(0, 8'h34, 1'b0);
        send_byte(0, 8'h56, 1'b1);
        wait_done(0);

        // Underrun: no second byte offered
        eb0.push_back(8'h01);
        push_frame(0, 40, 1, 1'b1);
        send_byte(0, 8'h01, 1'b0);
        wait_done(0);
        chk("underrun_sticky", int'(ur_0), 1);

        // Next frame clears underrun at accept
        eb0.push_back(8'h3C); eb0.push_back(8'h3C);
        push_frame(0, 64, 0, 1'b0);
        send_byte(0, 8'h3C, 1'b1);
        @(negedge clk);
        chk("underrun_cleared", int'(ur_0), 0);
        @(posedge clk); #1;
        wait_done(0);

        // Back-to-back frames: second byte waits through the first frame
        eb0.push_back(8'h81); eb0.push_back(8'h81);
        eb0.push_back(8'h7E); eb0.push_back(8'h7E);
        push_frame(0, 64, 0, 1'b0);
        push_frame(0, 64, 0, 1'b0);
        send_byte(0, 8'h81, 1'b1);
        fork
            send_byte(0, 8'h7E, 1'b1);
            begin
                seen = 1'b0;
                for (n = 0; n < 3000; n++) begin
                    @(negedge clk);
                    if (seen && !oe_0) break;
                    seen = seen | oe_0;
                end
                chk("b2b_ready_after_oe_drop", int'(if0.tx_ready && if0.tx_valid), 1);
                @(negedge clk);
                chk("b2b_accepted_oe_low", int'({busy_0, oe_0}), 2);
            end
        join
        wait_done(0);

        // Reset mid-frame during DATA
        send_byte(1, 8'hA5, 1'b1);
        n = 0;
        while (!(in_fr[1] && steps[1] >= 15) && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        chk("reached_data_before_reset", int'(in_fr[1]), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_lines_oe", int'({p1_1, p5_1, oe_1}), 6);
        chk("midreset_busy", int'(busy_1), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        viol = 0;
        repeat (80) begin
            @(negedge clk);
            if (oe_1 || !p1_1 || !p5_1 || busy_1) viol++;
        end
        chk("post_reset_quiet", viol, 0);

        chk("bytes_left_crc", eb0.size(), 0);
        chk("bytes_left_nocrc", eb1.size(), 0);
        chk("frames_left", ef0.size() + ef1.size(), 0);
        chk("no_change_without_tick", stab_viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_maple_tx
`default_nettype wire
